// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the int_mul / int_mac / int_div datapath blocks.
// The helpers work on a 64-bit container; callers zero-extend their operands
// and size-cast the result back, so DATA_WIDTH up to 64 is supported.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } div_state_t;

    localparam int ARITH_MAX_W = 64;

    // Width of a counter that must be able to hold the value 'width'.
    function automatic int div_step_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Two's-complement negation.
    function automatic logic [ARITH_MAX_W-1:0] neg_val(input logic [ARITH_MAX_W-1:0] x);
        return ~x + ARITH_MAX_W'(1);
    endfunction

    // Magnitude of a value whose sign has already been decoded into is_neg.
    function automatic logic [ARITH_MAX_W-1:0] abs_val(input logic [ARITH_MAX_W-1:0] x,
                                                       input logic                   is_neg);
        return is_neg ? neg_val(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// {rem,quo} is shifted left by one, the divisor is trial-subtracted from the
// widened partial remainder and the result is kept only if non-negative.
module div_step #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);

    // One extra bit so the shifted remainder (< 2*divisor) and the sign of the
    // trial difference are both representable.
    logic [DATA_WIDTH:0] shifted_rem;
    logic [DATA_WIDTH:0] trial;

    // Shift, trial-subtract, restore on a negative difference.
    always_comb begin
        shifted_rem = {rem, quo[DATA_WIDTH-1]};
        trial       = shifted_rem - {1'b0, divisor};
        if (!trial[DATA_WIDTH]) begin
            rem_next = trial[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_rem[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/int_div.sv
// Iterative signed/unsigned integer divider with valid/ready handshakes.
// Magnitudes are divided with one restoring step per cycle, then a single FIX
// cycle applies sign correction and the divide-by-zero / overflow overrides.
// Latency from the accepting edge to out_valid is a constant DATA_WIDTH+2 edges.
// Optional build macro INT_DIV_DBZ_FLAG_EN adds the dbz and dbz_sticky outputs.
import arith_pkg::*;

module int_div #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
`ifdef INT_DIV_DBZ_FLAG_EN
    ,
    output logic                  dbz,
    output logic                  dbz_sticky
`endif
);

    localparam int                          DIV_STEP_CNT_W = div_step_cnt_w(DATA_WIDTH);
    localparam logic [DIV_STEP_CNT_W-1:0]   LAST_CNT       = DIV_STEP_CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0]       MOST_NEG       = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t                state_q, state_d;
    logic [DIV_STEP_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     rem_q, rem_d;
    logic [DATA_WIDTH-1:0]     quo_q, quo_d;
    logic [DATA_WIDTH-1:0]     dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0]     dvd_q, dvd_d;
    logic                      q_neg_q, q_neg_d;
    logic                      r_neg_q, r_neg_d;
    logic                      dbz_f_q, dbz_f_d;
    logic                      ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]     quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0]     remainder_q, remainder_d;
    logic                      out_valid_q, out_valid_d;
    logic                      in_ready_q, in_ready_d;
`ifdef INT_DIV_DBZ_FLAG_EN
    logic                      dbz_q, dbz_d;
    logic                      dbz_sticky_q, dbz_sticky_d;
`endif

    logic                      dvd_neg;
    logic                      dvs_neg;
    logic [DATA_WIDTH-1:0]     step_rem;
    logic [DATA_WIDTH-1:0]     step_quo;

    // is_signed only matters in the accept cycle; it is folded into the sign
    // and overflow flags rather than being kept as its own register.
    assign dvd_neg = is_signed & dividend[DATA_WIDTH-1];
    assign dvs_neg = is_signed & divisor[DATA_WIDTH-1];

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Next-state logic for the FSM, operand registers and result registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dbz_f_d     = dbz_f_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef INT_DIV_DBZ_FLAG_EN
        dbz_d        = dbz_q;
        dbz_sticky_d = dbz_sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    rem_d      = '0;
                    quo_d      = DATA_WIDTH'(abs_val(ARITH_MAX_W'(dividend), dvd_neg));
                    dvs_d      = DATA_WIDTH'(abs_val(ARITH_MAX_W'(divisor), dvs_neg));
                    dvd_d      = dividend;
                    q_neg_d    = dvd_neg ^ dvs_neg;
                    r_neg_d    = dvd_neg;
                    dbz_f_d    = (divisor == '0);
                    ovf_d      = is_signed && (dividend == MOST_NEG) && (divisor == '1);
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // The extra BUSY cycle at cnt==LAST keeps latency at DATA_WIDTH+2.
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + DIV_STEP_CNT_W'(1);
                end
            end
            FIX: begin
                if (dbz_f_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                end else if (ovf_q) begin
                    quotient_d  = MOST_NEG;
                    remainder_d = '0;
                end else begin
                    quotient_d  = q_neg_q ? DATA_WIDTH'(neg_val(ARITH_MAX_W'(quo_q))) : quo_q;
                    remainder_d = r_neg_q ? DATA_WIDTH'(neg_val(ARITH_MAX_W'(rem_q))) : rem_q;
                end
`ifdef INT_DIV_DBZ_FLAG_EN
                dbz_d        = dbz_f_q;
                dbz_sticky_d = dbz_sticky_q | dbz_f_q;
`endif
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
`ifdef INT_DIV_DBZ_FLAG_EN
                    dbz_d       = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and data registers; reset aborts any divide in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            dvd_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            dbz_f_q      <= 1'b0;
            ovf_q        <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
`ifdef INT_DIV_DBZ_FLAG_EN
            dbz_q        <= 1'b0;
            dbz_sticky_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            dvd_q        <= dvd_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            dbz_f_q      <= dbz_f_d;
            ovf_q        <= ovf_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
`ifdef INT_DIV_DBZ_FLAG_EN
            dbz_q        <= dbz_d;
            dbz_sticky_q <= dbz_sticky_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef INT_DIV_DBZ_FLAG_EN
    assign dbz        = dbz_q;
    assign dbz_sticky = dbz_sticky_q;
`endif

endmodule
